fighter_motion_p1: RTL

Player-1 position integrator for the fighting-game datapath. Once per video frame it combines the walk controls with the signed knockback velocity from the player-1 knockback controller, clamps the result to the arena, and registers the new X/Y position. Xpos feeds back into the knockback controller's wall-distance logic and forward into the sprite renderer and hit detection. A jump/gravity state machine drives Ypos.

---
 rtl/fighter_pkg.sv | 19 +
 rtl/fighter_jump_fsm.sv | 92 +++++++++
 rtl/fighter_motion_p1.sv | 108 ++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared fighter definitions: jump-state encoding, arena bounds and the
// knockback saturation limit. Also used by the knockback controller.
package fighter_pkg;

  // Vertical motion phases of the jump state machine
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_e;

  // Arena bounds shared with the knockback controller
  localparam int X_MIN = 10;
  localparam int X_MAX = 629;

  // Largest horizontal speed accepted from the knockback controller
  localparam int KNOCK_SAT = 64;

endpackage

// File: rtl/fighter_jump_fsm.sv
// Jump/gravity state machine for one fighter. Owns the vertical speed and
// the Y position; every update happens on a frame_tick edge only.
// The current state is exposed on the state output as a probe point.
module fighter_jump_fsm
  import fighter_pkg::*;
#(
  parameter int GROUND_Y = 400,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               jump,
  output logic signed [31:0] ypos,
  output logic               airborne,
  output jump_state_e        state
);

  jump_state_e        state_q, state_d;
  logic signed [31:0] vy_q, vy_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] vy_tmp;
  logic signed [31:0] y_tmp;

  // State, speed and height registers; reset lands the fighter at rest
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GROUND;
      vy_q    <= '0;
      y_q     <= GROUND_Y;
    end else begin
      state_q <= state_d;
      vy_q    <= vy_d;
      y_q     <= y_d;
    end
  end

  // Next-state physics: nothing moves unless frame_tick is high
  always_comb begin
    state_d = state_q;
    vy_d    = vy_q;
    y_d     = y_q;
    vy_tmp  = '0;
    y_tmp   = '0;
    if (frame_tick) begin
      unique case (state_q)
        GROUND: begin
          // Take-off tick: speed is loaded but height does not change yet
          if (jump) begin
            state_d = RISE;
            vy_d    = JUMP_V;
          end
        end
        RISE: begin
          y_d    = y_q - vy_q;
          vy_tmp = vy_q - GRAVITY;
          if (vy_tmp <= 0) begin
            state_d = FALL;
            vy_d    = '0;
          end else begin
            vy_d = vy_tmp;
          end
        end
        FALL: begin
          vy_tmp = vy_q + GRAVITY;
          y_tmp  = y_q + vy_tmp;
          if (y_tmp >= GROUND_Y) begin
            // Landing tick: jump is not sampled here, so a held jump
            // retriggers on the following tick
            state_d = GROUND;
            vy_d    = '0;
            y_d     = GROUND_Y;
          end else begin
            vy_d = vy_tmp;
            y_d  = y_tmp;
          end
        end
        default: begin
          state_d = GROUND;
          vy_d    = '0;
          y_d     = GROUND_Y;
        end
      endcase
    end
  end

  assign ypos     = y_q;
  assign airborne = (state_q != GROUND);
  assign state    = state_q;

endmodule

// File: rtl/fighter_motion_p1.sv
// Player-1 position integrator. Once per frame_tick it merges walk input with
// the knockback velocity, clamps X to the arena and registers the result.
// Build option FIGHTER_JUMP_EN: when defined the jump FSM drives Ypos and
// airborne; when undefined the fighter stays on the ground.
module fighter_motion_p1 #(
  parameter int X_MIN     = fighter_pkg::X_MIN,
  parameter int X_MAX     = fighter_pkg::X_MAX,
  parameter int FIGHTER_W = 32,
  parameter int START_X   = 100,
  parameter int GROUND_Y  = 400,
  parameter int WALK_STEP = 3,
  parameter int JUMP_V    = 12,
  parameter int GRAVITY   = 1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               left,
  input  logic               right,
  input  logic               jump,
  input  logic signed [31:0] knock_x,
  output logic signed [31:0] Xpos,
  output logic signed [31:0] Ypos,
  output logic signed [31:0] dx_applied,
  output logic               at_left_wall,
  output logic               at_right_wall,
  output logic               airborne
);

  import fighter_pkg::*;

  // Rightmost legal Xpos keeps the whole sprite inside the arena
  localparam int X_RIGHT = X_MAX - FIGHTER_W;

  logic signed [31:0] xpos_q;
  logic signed [31:0] dx_q;
  logic               left_wall_q;
  logic               right_wall_q;
  logic signed [31:0] raw_dx;
  logic signed [31:0] x_sum;
  logic signed [31:0] x_next;

  // Raw velocity selection and arena clamp; knockback overrides walking
  always_comb begin
    raw_dx = '0;
    if (knock_x != 0) begin
      if (knock_x > KNOCK_SAT)       raw_dx = KNOCK_SAT;
      else if (knock_x < -KNOCK_SAT) raw_dx = -KNOCK_SAT;
      else                           raw_dx = knock_x;
    end else if (right && !left) begin
      raw_dx = WALK_STEP;
    end else if (left && !right) begin
      raw_dx = -WALK_STEP;
    end
    // Saturated speed plus an in-arena Xpos cannot overflow 32 bits
    x_sum = xpos_q + raw_dx;
    if (x_sum < X_MIN)        x_next = X_MIN;
    else if (x_sum > X_RIGHT) x_next = X_RIGHT;
    else                      x_next = x_sum;
  end

  // X position, applied delta and wall flags, updated once per frame
  always_ff @(posedge clk) begin
    if (Reset) begin
      xpos_q       <= START_X;
      dx_q         <= '0;
      left_wall_q  <= 1'b0;
      right_wall_q <= 1'b0;
    end else if (frame_tick) begin
      xpos_q       <= x_next;
      dx_q         <= x_next - xpos_q;
      left_wall_q  <= (x_next == X_MIN);
      right_wall_q <= (x_next == X_RIGHT);
    end
  end

  assign Xpos          = xpos_q;
  assign dx_applied    = dx_q;
  assign at_left_wall  = left_wall_q;
  assign at_right_wall = right_wall_q;

`ifdef FIGHTER_JUMP_EN
  // FSM state is kept as a probe point for checkers; no top-level logic uses it
  jump_state_e unused_jump_state;

  fighter_jump_fsm #(
    .GROUND_Y (GROUND_Y),
    .JUMP_V   (JUMP_V),
    .GRAVITY  (GRAVITY)
  ) u_jump_fsm (
    .clk        (clk),
    .reset      (Reset),
    .frame_tick (frame_tick),
    .jump       (jump),
    .ypos       (Ypos),
    .airborne   (airborne),
    .state      (unused_jump_state)
  );
`else
  // Ground-only build: jump input and jump tuning have no effect
  logic unused_jump;
  localparam int unused_jump_params = JUMP_V + GRAVITY;
  assign unused_jump = jump;
  assign Ypos        = GROUND_Y;
  assign airborne    = 1'b0;
`endif

endmodule
